// File: rtl/way_hit_plru_unit.sv
// N-way hit encoder with per-set tree pseudo-LRU victim selection and a sticky multi-hit error flag.
// Optional hit/miss counters are built when HIT_COUNTERS_EN is defined.
module way_hit_plru_unit #(
   parameter int WAYS     = 4,
   parameter int SETS     = 8,
   parameter int WAY_BITS = $clog2(WAYS),
   parameter int IDX_BITS = $clog2(SETS)
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                access_valid,
   input  logic [IDX_BITS-1:0] access_index,
   input  logic [WAYS-1:0]     way_hit_vec,
   input  logic                fill_valid,
   input  logic [IDX_BITS-1:0] fill_index,
   input  logic [WAY_BITS-1:0] fill_way,
   input  logic                err_clear,
   output logic                hit,
   output logic [WAY_BITS-1:0] way_hit,
   output logic                multi_hit,
   output logic [WAY_BITS-1:0] victim_way,
   output logic                multi_hit_err,
   output logic [15:0]         hit_count,
   output logic [15:0]         miss_count
);

   localparam int NODES = WAYS - 1;

   logic [SETS-1:0][NODES-1:0] plru_r;
   logic [SETS-1:0][NODES-1:0] plru_next_s;
   logic [NODES-1:0]           access_set_s;
   logic [NODES-1:0]           fill_base_s;
   logic [WAY_BITS-1:0]        enc_s;
   logic                       any_hit_s;
   logic                       many_hit_s;
   logic                       access_touch_s;
   logic                       multi_hit_err_r;

   // Point every node on the path of 'way' away from it (heap order, MSB of way picks at root).
   function automatic logic [NODES-1:0] plru_touch(input logic [NODES-1:0] bits,
                                                   input logic [WAY_BITS-1:0] way);
      logic [NODES-1:0]    res;
      logic [WAY_BITS-1:0] node;
      int                  n;
      res = bits;
      n   = 0;
      for (int l = 0; l < WAY_BITS; l++) begin
         node      = WAY_BITS'(n);
         res[node] = ~way[WAY_BITS-1-l];
         n         = 2 * n + 1 + int'(way[WAY_BITS-1-l]);
      end
      return res;
   endfunction

   function automatic logic [WAY_BITS-1:0] plru_victim(input logic [NODES-1:0] bits);
      logic [WAY_BITS-1:0] vic;
      logic [WAY_BITS-1:0] node;
      int                  n;
      vic = {WAY_BITS{1'b0}};
      n   = 0;
      for (int l = 0; l < WAY_BITS; l++) begin
         node                = WAY_BITS'(n);
         vic[WAY_BITS-1-l]   = bits[node];
         n                   = 2 * n + 1 + int'(bits[node]);
      end
      return vic;
   endfunction

   function automatic logic [WAY_BITS-1:0] lowest_way(input logic [WAYS-1:0] vec);
      logic [WAY_BITS-1:0] enc;
      enc = {WAY_BITS{1'b0}};
      for (int i = WAYS - 1; i >= 0; i--) begin
         enc = vec[i] ? WAY_BITS'(i) : enc;
      end
      return enc;
   endfunction

   assign enc_s          = lowest_way(way_hit_vec);
   assign any_hit_s      = |way_hit_vec;
   assign many_hit_s     = (way_hit_vec & (way_hit_vec - WAYS'(1))) != {WAYS{1'b0}};
   assign access_touch_s = access_valid & any_hit_s & ~many_hit_s;

   assign hit           = access_valid & any_hit_s;
   assign multi_hit     = access_valid & many_hit_s;
   assign way_hit       = access_valid ? enc_s : {WAY_BITS{1'b0}};
   assign victim_way    = plru_victim(plru_r[access_index]);
   assign multi_hit_err = multi_hit_err_r;

   // Next PLRU state: access touch first, then fill touch so the fill wins on shared nodes.
   always_comb begin
      plru_next_s               = plru_r;
      access_set_s              = access_touch_s ? plru_touch(plru_r[access_index], enc_s)
                                                 : plru_r[access_index];
      plru_next_s[access_index] = access_set_s;
      fill_base_s               = plru_next_s[fill_index];
      plru_next_s[fill_index]   = fill_valid ? plru_touch(fill_base_s, fill_way) : fill_base_s;
   end

   // PLRU state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         plru_r <= {(SETS*NODES){1'b0}};
      end else begin
         plru_r <= plru_next_s;
      end
   end

   // Sticky multi-hit error; a new multi-hit beats a same-cycle clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         multi_hit_err_r <= 1'b0;
      end else if (access_valid && many_hit_s) begin
         multi_hit_err_r <= 1'b1;
      end else if (err_clear) begin
         multi_hit_err_r <= 1'b0;
      end else begin
         multi_hit_err_r <= multi_hit_err_r;
      end
   end

`ifdef HIT_COUNTERS_EN
   logic [15:0] hit_count_r;
   logic [15:0] miss_count_r;

   // Saturating hit/miss counters; a multi-hit counts as a hit.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hit_count_r  <= 16'h0000;
         miss_count_r <= 16'h0000;
      end else if (access_valid && any_hit_s) begin
         hit_count_r  <= (hit_count_r == 16'hFFFF) ? hit_count_r : hit_count_r + 16'd1;
         miss_count_r <= miss_count_r;
      end else if (access_valid) begin
         hit_count_r  <= hit_count_r;
         miss_count_r <= (miss_count_r == 16'hFFFF) ? miss_count_r : miss_count_r + 16'd1;
      end else begin
         hit_count_r  <= hit_count_r;
         miss_count_r <= miss_count_r;
      end
   end

   assign hit_count  = hit_count_r;
   assign miss_count = miss_count_r;
`else
   assign hit_count  = 16'h0000;
   assign miss_count = 16'h0000;
`endif

endmodule
